// File: rtl/uart_wb_cmd_master.sv
// uart_wb_cmd_master
//   ASCII command interpreter bridging a UART byte stream to a Wishbone
//   classic master. It accepts "R<addr>\n" and "W<addr> <data>\n" (hex,
//   either case, CR or LF terminator). It runs one single transfer per
//   command, with a timeout. It answers with read data in hex, 'K', 'E'
//   or 'T', and each answer ends in LF.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   rx_data/rx_valid   incoming UART byte strobe
//   rx_drop            pulse: a byte arrived while busy and was discarded
//   tx_data/tx_valid/tx_ready  response byte stream (valid/ready)
//   wb_*               Wishbone classic master port
//   busy               high whenever the FSM is not idle
module uart_wb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_drop,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WB, S_RESP} state_t;
  typedef enum logic [1:0] {R_OK, R_ERR, R_TMO} resp_t;

  localparam int NDIG = DW / 4;
  localparam int IW   = $clog2(NDIG + 1);
  // The timeout counter only needs to reach TIMEOUT-1.
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] RD_LAST  = IW'(NDIG);

  state_t          state, state_n;
  resp_t           resp, resp_n;
  logic            mode, mode_n;          // 1 = write
  logic [AW-1:0]   addr, addr_n;
  logic [DW-1:0]   data, data_n;          // write data, or latched read data
  logic [3:0]      naddr, naddr_n;        // saturating digit counts
  logic [3:0]      ndata, ndata_n;
  logic [CW-1:0]   tmo_cnt, tmo_n;
  logic [IW-1:0]   idx, idx_n;            // response byte index

  logic            hex_ok, is_term, is_sep;
  logic [3:0]      nib;
  logic [IW-1:0]   last_idx;
  logic [DW-1:0]   shifted;

  function automatic logic [4:0] hex_dec(input logic [7:0] b);
    logic [7:0] t;
    t = 8'h00;
    if (b >= 8'h30 && b <= 8'h39) begin
      t = b - 8'h30;
      return {1'b1, t[3:0]};
    end
    if (b >= 8'h61 && b <= 8'h66) begin
      t = b - 8'h57;
      return {1'b1, t[3:0]};
    end
    if (b >= 8'h41 && b <= 8'h46) begin
      t = b - 8'h37;
      return {1'b1, t[3:0]};
    end
    return 5'b0;
  endfunction

  function automatic logic [7:0] hex_asc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    resp_n  = resp;
    mode_n  = mode;
    addr_n  = addr;
    data_n  = data;
    naddr_n = naddr;
    ndata_n = ndata;
    tmo_n   = tmo_cnt;
    idx_n   = idx;

    {hex_ok, nib} = hex_dec(rx_data);
    is_term  = (rx_data == 8'h0A) || (rx_data == 8'h0D);
    is_sep   = (rx_data == 8'h20);
    last_idx = (resp == R_OK && !mode) ? RD_LAST : IW'(1);

    unique case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == 8'h52 || rx_data == 8'h72 ||
                         rx_data == 8'h57 || rx_data == 8'h77)) begin
          state_n = S_ADDR;
          mode_n  = (rx_data == 8'h57 || rx_data == 8'h77);
          addr_n  = '0;
          data_n  = '0;
          naddr_n = '0;
          ndata_n = '0;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (hex_ok) begin
            addr_n  = (addr << 4) | AW'(nib);
            naddr_n = (naddr == 4'hF) ? naddr : naddr + 4'd1;
          end else if (is_sep && mode && naddr != 4'd0) begin
            state_n = S_DATA;
          end else if (is_term && !mode && naddr != 4'd0) begin
            state_n = S_WB;
            tmo_n   = '0;
          end else begin
            state_n = S_RESP;
            resp_n  = R_ERR;
            idx_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (hex_ok) begin
            data_n  = (data << 4) | DW'(nib);
            ndata_n = (ndata == 4'hF) ? ndata : ndata + 4'd1;
          end else if (is_term && ndata != 4'd0) begin
            state_n = S_WB;
            tmo_n   = '0;
          end else begin
            state_n = S_RESP;
            resp_n  = R_ERR;
            idx_n   = '0;
          end
        end
      end
      S_WB: begin
        // Error beats ack, and ack beats timeout expiry in the same cycle.
        state_n = S_RESP;
        idx_n   = '0;
        if (wb_err_i) begin
          resp_n = R_ERR;
        end else if (wb_ack_i) begin
          resp_n = R_OK;
          if (!mode) data_n = wb_dat_i;
        end else if (tmo_cnt == TMO_LAST) begin
          resp_n = R_TMO;
        end else begin
          state_n = S_WB;
          tmo_n   = tmo_cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          if (idx == last_idx) state_n = S_IDLE;
          else                 idx_n   = idx + IW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Response byte: hex digits MSB first for a read, else a single letter,
  // and always a trailing LF.
  always_comb begin
    tx_data = 8'h00;
    shifted = '0;
    if (state == S_RESP) begin
      if (idx == last_idx) begin
        tx_data = 8'h0A;
      end else begin
        unique case (resp)
          R_OK: begin
            if (mode) begin
              tx_data = 8'h4B;
            end else begin
              shifted = data >> (4 * (NDIG - 1 - int'(idx)));
              tx_data = hex_asc(shifted[3:0]);
            end
          end
          R_ERR:   tx_data = 8'h45;
          default: tx_data = 8'h54;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      resp    <= R_OK;
      mode    <= 1'b0;
      addr    <= '0;
      data    <= '0;
      naddr   <= '0;
      ndata   <= '0;
      tmo_cnt <= '0;
      idx     <= '0;
      rx_drop <= 1'b0;
    end else begin
      state   <= state_n;
      resp    <= resp_n;
      mode    <= mode_n;
      addr    <= addr_n;
      data    <= data_n;
      naddr   <= naddr_n;
      ndata   <= ndata_n;
      tmo_cnt <= tmo_n;
      idx     <= idx_n;
      rx_drop <= rx_valid && (state == S_WB || state == S_RESP);
    end
  end

  // Bus outputs are gated by state so they read zero outside a transfer.
  assign wb_cyc_o = (state == S_WB);
  assign wb_stb_o = (state == S_WB);
  assign wb_we_o  = (state == S_WB) && mode;
  assign wb_adr_o = (state == S_WB) ? addr : '0;
  assign wb_dat_o = (state == S_WB && mode) ? data : '0;
  assign wb_sel_o = (state == S_WB) ? '1 : '0;
  assign tx_valid = (state == S_RESP);
  assign busy     = (state != S_IDLE);

endmodule
